count_sequence_monitor: RTL and testbench

//  - Downstream checker for the JK-based binary counter: samples its q outputs (as a packed bus) and

---
 rtl/count_sequence_monitor.sv | 115 +++++++++++
 tb/tb_count_sequence_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_monitor.sv
// count_sequence_monitor: checks that a sampled counter bus advances by
// exactly +1 (mod 2^WIDTH) on every enabled edge. Locks after LOCK_MATCHES
// consecutive good steps; while locked it pulses seq_err on a bad step and
// wrap_pulse on a good max->0 step, and keeps a saturating error tally.
// Optional build macro: HOLD_OK_EN -- treat count_in==prev as a legal hold.
module count_sequence_monitor #(
  parameter int WIDTH        = 4,
  parameter int LOCK_MATCHES = 3,
  parameter int ERR_W        = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clear_err,
  output logic             locked,
  output logic             seq_err,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {UNLOCKED, LOCKING, LOCKED} state_t;

  localparam logic [3:0]       LM      = LOCK_MATCHES[3:0];
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       match_cnt;
  logic [WIDTH-1:0] prev_inc;
  logic             good;
  logic             hold;
  logic             err_evt;

  // Expected next value wraps naturally in WIDTH bits.
  assign prev_inc = prev + ONE;
  assign good     = (count_in == prev_inc);

`ifdef HOLD_OK_EN
  // A repeated value is a legal hold of the counter, neither good nor bad.
  assign hold = (count_in == prev);
`else
  assign hold = 1'b0;
`endif

  // A bad step only counts as an error once lock has been acquired.
  assign err_evt = enable && (state == LOCKED) && !good && !hold;

  // Lock FSM, sample history and single-cycle event flags.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= UNLOCKED;
      prev       <= '0;
      match_cnt  <= '0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      seq_err    <= 1'b0;
      wrap_pulse <= 1'b0;
      if (enable) begin
        prev <= count_in;
        case (state)
          UNLOCKED: begin
            match_cnt <= '0;
            state     <= LOCKING;
            locked    <= 1'b0;
          end
          LOCKING: begin
            if (good) begin
              if (match_cnt + 4'd1 == LM) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
              end else begin
                match_cnt <= match_cnt + 4'd1;
              end
            end else if (!hold) begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            if (good) begin
              wrap_pulse <= (prev == CNT_MAX);
            end else if (!hold) begin
              seq_err   <= 1'b1;
              state     <= LOCKING;
              locked    <= 1'b0;
              match_cnt <= '0;
            end
          end
          default: begin
            state     <= UNLOCKED;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Saturating error tally; clear wins over a coincident error and works even
  // on disabled edges.
  always_ff @(posedge clock) begin
    if (!reset_n)
      err_count <= '0;
    else if (clear_err)
      err_count <= '0;
    else if (err_evt && (err_count != ERR_MAX))
      err_count <= err_count + {{(ERR_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Randomized self-checking bench for count_sequence_monitor. The reference
// model tracks the length of the current run of good steps: the monitor is
// locked whenever that run has reached LOCK_MATCHES.
module tb_count_sequence_monitor;

  localparam int WIDTH = 4;
  localparam int LM    = 3;
  localparam int ERR_W = 8;
  localparam int MOD   = 1 << WIDTH;
  localparam int EMAX  = (1 << ERR_W) - 1;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             enable = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             clear_err = 1'b0;
  logic             locked, seq_err, wrap_pulse;
  logic [ERR_W-1:0] err_count;

  int errs = 0;
  int checks = 0;

  // reference model
  bit m_have, m_lock, m_se, m_wp;
  int m_prev, m_run, m_ec;
  int cnt;

  count_sequence_monitor #(.WIDTH(WIDTH), .LOCK_MATCHES(LM), .ERR_W(ERR_W)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .count_in(count_in),
    .clear_err(clear_err), .locked(locked), .seq_err(seq_err),
    .wrap_pulse(wrap_pulse), .err_count(err_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit en, input int c, input bit clr, input bit rst);
    int d;
    if (!rst) begin
      m_have = 0; m_prev = 0; m_run = 0; m_lock = 0;
      m_se = 0; m_wp = 0; m_ec = 0;
      return;
    end
    m_se = 0; m_wp = 0;
    if (en) begin
      if (!m_have) begin
        m_have = 1; m_run = 0;
      end else begin
        d = (c - m_prev + MOD) % MOD;
        if (d == 1) begin
          if (m_lock && m_prev == MOD - 1) m_wp = 1;
          if (m_run < 1000) m_run++;
        end
`ifdef HOLD_OK_EN
        else if (d == 0) begin
        end
`endif
        else begin
          if (m_lock) begin
            m_se = 1;
            if (m_ec < EMAX) m_ec++;
          end
          m_run = 0;
        end
      end
      m_prev = c;
      m_lock = m_have && (m_run >= LM);
    end
    if (clr) m_ec = 0;
  endtask

  // One clock: drive, edge, model, then check all outputs 1 time unit later.
  task automatic cyc(input bit en, input int c, input bit clr, input bit rst);
    enable = en; count_in = c[WIDTH-1:0]; clear_err = clr; reset_n = rst;
    @(posedge clock);
    model_edge(en, c, clr, rst);
    #1;
    chk("locked", locked, m_lock);
    chk("seq_err", seq_err, m_se);
    chk("wrap_pulse", wrap_pulse, m_wp);
    chk("err_count", err_count, m_ec);
    chk("no_both", seq_err & wrap_pulse, 0);
  endtask

  task automatic good(input int c);
    cyc(1, c % MOD, 0, 1);
  endtask

  initial begin
    // reset state
    cyc(1, 5, 1, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);

    // initial lock: 0,1,2,3
    for (int i = 0; i < 3; i++) begin
      good(i);
      chk("prelock", locked, 0);
    end
    good(3);
    chk("lock_rise", locked, 1);

    // wrap through 15 -> 0
    for (int i = 4; i < 16; i++) good(i);
    good(0);
    chk("wrap_hi", wrap_pulse, 1);
    good(1);
    chk("wrap_lo", wrap_pulse, 0);
    chk("wrap_noerr", err_count, 0);

    // error at 5 -> 9, then relock on 10,11,12
    for (int i = 2; i < 6; i++) good(i);
    cyc(1, 9, 0, 1);
    chk("inj_se", seq_err, 1);
    chk("inj_ec", err_count, 1);
    chk("inj_unlock", locked, 0);
    good(10); good(11);
    chk("relock_pre", locked, 0);
    good(12);
    chk("relock", locked, 1);

    // hold 7,7
    cyc(1, 0, 0, 0);
    for (int i = 4; i < 8; i++) good(i);
    good(7);
`ifdef HOLD_OK_EN
    chk("hold_se", seq_err, 0);
    chk("hold_lock", locked, 1);
`else
    chk("hold_se", seq_err, 1);
    chk("hold_ec", err_count, 1);
`endif

    // 300 errors saturate at 255
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) good(i);
    cnt = 3;
    for (int k = 0; k < 300; k++) begin
      cnt = (cnt + 5) % MOD;
      cyc(1, cnt, 0, 1);
      for (int j = 0; j < LM; j++) begin
        cnt = (cnt + 1) % MOD;
        good(cnt);
      end
    end
    chk("sat", err_count, EMAX);
    cnt = (cnt + 5) % MOD;
    cyc(1, cnt, 1, 1);
    chk("clr_win_ec", err_count, 0);
    chk("clr_win_se", seq_err, 1);

    // reset mid-lock, then relock
    for (int j = 0; j < LM; j++) begin
      cnt = (cnt + 1) % MOD;
      good(cnt);
    end
    chk("pre_rst_lock", locked, 1);
    cyc(1, cnt + 1, 0, 0);
    chk("mid_rst_lock", locked, 0);
    chk("mid_rst_se", seq_err, 0);
    chk("mid_rst_wp", wrap_pulse, 0);
    good(8); good(9); good(10);
    chk("post_rst_pre", locked, 0);
    good(11);
    chk("post_rst_lock", locked, 1);

    // disabled edges freeze state; clear still works
    cyc(0, 3, 0, 1);
    chk("en0_lock", locked, 1);

    // randomized traffic
    cnt = 11;
    for (int n = 0; n < 4000; n++) begin
      bit en, clr, rst;
      int r, c;
      en  = ($urandom % 8) != 0;
      clr = ($urandom % 40) == 0;
      rst = ($urandom % 250) != 0;
      r = $urandom % 16;
      if (r < 12)      c = (cnt + 1) % MOD;
      else if (r < 14) c = cnt;
      else             c = $urandom % MOD;
      cyc(en, c, clr, rst);
      if (en) cnt = c;
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
